spi_reg_bridge: RTL and testbench



---
 rtl/spi_reg_bridge_pkg.sv | 23 ++
 rtl/spi_reg_bridge_if.sv | 52 +++++
 rtl/spi_reg_bridge_sync.sv | 50 +++++
 rtl/spi_reg_bridge.sv | 172 +++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : spi_bridge_pkg                                               |
// | Purpose   : Shared types and constants for the SPI register bridge.      |
// |             state_t : frame FSM states                                   |
// |             CMD_W   : command byte length in bits                        |
// |             WR_BIT  : command bit that selects a write frame             |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CMD_W  = 8;
  localparam int WR_BIT = 7;

endpackage
`default_nettype wire

// File: rtl/spi_reg_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : spi_reg_bridge_if                                            |
// | Purpose   : Bundles the SPI pins and the register-side signals of the    |
// |             bridge.                                                      |
// |   spi_sclk/spi_cs_n/spi_mosi : async SPI inputs (mode 0)                 |
// |   spi_miso                   : SPI data out                              |
// |   spi_miso_oe                : pad output enable (SPI_MISO_OE_EN only)   |
// |   reg_we/reg_wdata           : register write strobe and data            |
// |   reg_rdata                  : register read-back value                  |
// |   frame_err                  : early-deselect pulse                      |
// | Modports  : slave (bridge side), master (SPI host / register side)       |
// | Macro     : SPI_MISO_OE_EN adds spi_miso_oe                              |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface spi_reg_bridge_if #(
  parameter int DATA_W = 8
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
`ifdef SPI_MISO_OE_EN
  logic              spi_miso_oe;
`endif
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              frame_err;

`ifdef SPI_MISO_OE_EN
  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
    output spi_miso, spi_miso_oe, reg_we, reg_wdata, frame_err
  );
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
    input  spi_miso, spi_miso_oe, reg_we, reg_wdata, frame_err
  );
`else
  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
    output spi_miso, reg_we, reg_wdata, frame_err
  );
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
    input  spi_miso, reg_we, reg_wdata, frame_err
  );
`endif

endinterface
`default_nettype wire

// File: rtl/spi_reg_bridge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : spi_sync                                                     |
// | Purpose   : Multi-flop synchroniser with optional rise/fall detection    |
// |             on the synchronised level.                                   |
// |   clk, rst_n : system clock, async active-low reset                      |
// |   async_in   : asynchronous input                                        |
// |   sync_out   : synchronised level                                        |
// |   rise, fall : one-cycle edge pulses (tied 0 when EDGE_EN=0)             |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module spi_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0,
  parameter bit EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= RESET_VAL;
        else        prev_q <= sync_out;
      end
      assign rise = sync_out & ~prev_q;
      assign fall = ~sync_out & prev_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : spi_reg_bridge                                               |
// | Purpose   : SPI mode-0 slave turning 16-bit frames (command byte, data   |
// |             byte, MSB first) into register write strobes and read-back. |
// |   clk   : system clock (must be >= 6x SPI clock)                         |
// |   rst_n : asynchronous active-low reset                                  |
// |   bus   : spi_reg_bridge_if.slave (SPI pins + register side)             |
// | Macro     : SPI_MISO_OE_EN adds bus.spi_miso_oe = ~synced cs_n           |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_reg_bridge_if.slave  bus
);
  import spi_bridge_pkg::*;

  localparam int PH_MAX = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(bus.spi_sclk),
    .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall));

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .async_in(bus.spi_cs_n),
    .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall));

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .async_in(bus.spi_mosi),
    .sync_out(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  // Level of sclk and the cs/mosi edges carry no information for the FSM.
  logic unused_sync;
  assign unused_sync = ^{sclk_s, cs_fall, mosi_rise, mosi_fall};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CMD_W-1:0]  cmd_sr, cmd_sr_nxt, cmd_shift;
  logic [DATA_W-1:0] data_sr, data_sr_nxt, data_shift;
  logic [DATA_W-1:0] rd_sr, rd_sr_nxt;
  logic [DATA_W-1:0] wdata, wdata_nxt;
  logic              wr_flag, wr_flag_nxt;
  logic              miso, miso_nxt;
  logic              we, we_nxt;
  logic              err, err_nxt;
  logic              last_data;

  assign cmd_shift  = (cmd_sr << 1) | CMD_W'(mosi_s);
  assign data_shift = (data_sr << 1) | DATA_W'(mosi_s);
  assign last_data  = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd_sr  <= '0;
      data_sr <= '0;
      rd_sr   <= '0;
      wdata   <= '0;
      wr_flag <= 1'b0;
      miso    <= 1'b0;
      we      <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cmd_sr  <= cmd_sr_nxt;
      data_sr <= data_sr_nxt;
      rd_sr   <= rd_sr_nxt;
      wdata   <= wdata_nxt;
      wr_flag <= wr_flag_nxt;
      miso    <= miso_nxt;
      we      <= we_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cmd_sr_nxt  = cmd_sr;
    data_sr_nxt = data_sr;
    rd_sr_nxt   = rd_sr;
    wdata_nxt   = wdata;
    wr_flag_nxt = wr_flag;
    miso_nxt    = 1'b0;
    we_nxt      = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (!cs_s) begin
          state_nxt   = CMD;
          cnt_nxt     = '0;
          cmd_sr_nxt  = '0;
          data_sr_nxt = '0;
          rd_sr_nxt   = '0;
        end
      end

      CMD: begin
        if (sclk_rise) begin
          cmd_sr_nxt = cmd_shift;
          cnt_nxt    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(CMD_W - 1)) begin
            wr_flag_nxt = cmd_shift[WR_BIT];
            rd_sr_nxt   = bus.reg_rdata;  // snapshot taken with the 8th bit
            cnt_nxt     = '0;
            state_nxt   = DATA;
          end
        end
        if (cs_rise) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end

      DATA: begin
        miso_nxt = miso;
        if (sclk_fall) begin
          miso_nxt  = rd_sr[DATA_W-1];
          rd_sr_nxt = rd_sr << 1;
        end
        if (sclk_rise) begin
          data_sr_nxt = data_shift;
          cnt_nxt     = cnt + CNT_W'(1);
          if (last_data) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
            miso_nxt  = 1'b0;
            if (wr_flag) begin
              wdata_nxt = data_shift;
              we_nxt    = 1'b1;
            end
          end
        end
        // A deselect coinciding with the final bit still completes the frame.
        if (cs_rise && !(sclk_rise && last_data)) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          miso_nxt  = 1'b0;
        end
      end

      DONE: begin
        // Level test so a deselect seen with the last bit is not missed.
        if (cs_s) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.spi_miso  = miso;
  assign bus.reg_we    = we;
  assign bus.reg_wdata = wdata;
  assign bus.frame_err = err;
`ifdef SPI_MISO_OE_EN
  assign bus.spi_miso_oe = ~cs_s;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_spi_reg_bridge                                            |
// | Purpose   : Self-checking bench for spi_reg_bridge. Directed frames plus |
// |             randomized frames, checked against a frame-level model.      |
// | Macro     : SPI_MISO_OE_EN also checks spi_miso_oe reset value           |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_spi_reg_bridge;

  localparam int DATA_W = 8;
  localparam int H      = 8;   // clk cycles per sclk half period

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_reg_bridge_if #(.DATA_W(DATA_W)) bus ();

  spi_reg_bridge #(.SYNC_STAGES(2), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Frame-level model state
  logic [7:0] wq[$];          // writes still owed by the DUT, in order
  logic [7:0] last_w  = 8'h00; // value reg_wdata must hold
  int         err_seen = 0;
  int         we_seen  = 0;
  logic [7:0] got_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle compare: every strobe must match the next owed write, and
  // reg_wdata must otherwise hold the last written value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reg_we === 1'b1) begin
        check("we_pending", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          check("wdata_on_we", 32'(bus.reg_wdata), 32'(wq[0]));
          last_w = wq.pop_front();
        end
        we_seen++;
      end else begin
        check("wdata_hold", 32'(bus.reg_wdata), 32'(last_w));
      end
      if (bus.frame_err === 1'b1) err_seen++;
      check("we_err_excl", 32'(bus.reg_we & bus.frame_err), 32'd0);
    end
  end

  // Drive one frame of nbits bits (MSB of 'bits' first). miso is sampled
  // just before each rising sclk, as a master would.
  task automatic spi_frame(input logic [31:0] bits, input int nbits,
                           input logic [7:0] rdata, input bit cs_with_last,
                           input int gap);
    int   err0;
    bit   aborted;
    logic exp_b;
    err0    = err_seen;
    aborted = (nbits < 16);
    if (bits[31] && !aborted) wq.push_back(bits[23:16]);
    bus.reg_rdata = rdata;
    got_rd = 8'h00;
    wait_clk(H);
    bus.spi_cs_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = bits[31-i];
      wait_clk(H);
      exp_b = (i >= 8 && i < 16) ? rdata[15-i] : 1'b0;
      check($sformatf("miso_bit%0d", i), 32'(bus.spi_miso), 32'(exp_b));
      if (i >= 8 && i < 16) got_rd[15-i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      if (cs_with_last && i == nbits - 1) bus.spi_cs_n = 1'b1;
      wait_clk(H);
      bus.spi_sclk = 1'b0;
    end
    wait_clk(H);
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    wait_clk(gap);
    check("write_drained", 32'(wq.size()), 32'd0);
    check("frame_err_count", 32'(err_seen - err0), aborted ? 32'd1 : 32'd0);
  endtask

  initial begin
    int we0;
    bus.spi_sclk  = 1'b0;
    bus.spi_cs_n  = 1'b1;
    bus.spi_mosi  = 1'b0;
    bus.reg_rdata = '0;
    rst_n = 1'b0;
    wait_clk(4);
    check("rst_we",    32'(bus.reg_we),    32'd0);
    check("rst_wdata", 32'(bus.reg_wdata), 32'd0);
    check("rst_err",   32'(bus.frame_err), 32'd0);
    check("rst_miso",  32'(bus.spi_miso),  32'd0);
`ifdef SPI_MISO_OE_EN
    check("rst_oe",    32'(bus.spi_miso_oe), 32'd0);
`endif
    rst_n = 1'b1;
    wait_clk(4);

    // 1: write 0x80,0x5A
    we0 = we_seen;
    spi_frame(32'h805A_0000, 16, 8'h3C, 1'b0, 4*H);
    check("t1_we_count", 32'(we_seen - we0), 32'd1);
    check("t1_wdata", 32'(bus.reg_wdata), 32'h5A);

    // 2: read 0x00,0x00 with read-back 0xC3
    we0 = we_seen;
    spi_frame(32'h0000_0000, 16, 8'hC3, 1'b0, 4*H);
    check("t2_rd_bits", 32'(got_rd), 32'hC3);
    check("t2_we_count", 32'(we_seen - we0), 32'd0);

    // 3: write 0x80,0xFF aborted after 11 bits
    we0 = we_seen;
    spi_frame(32'h80FF_0000, 11, 8'h00, 1'b0, 4*H);
    check("t3_we_count", 32'(we_seen - we0), 32'd0);
    check("t3_wdata", 32'(bus.reg_wdata), 32'h5A);

    // 4: 24 clocks 0x80,0x11,0x22
    we0 = we_seen;
    spi_frame(32'h8011_2200, 24, 8'h96, 1'b0, 4*H);
    check("t4_we_count", 32'(we_seen - we0), 32'd1);
    check("t4_wdata", 32'(bus.reg_wdata), 32'h11);

    // 5: back-to-back writes, cs high for two sclk periods
    we0 = we_seen;
    spi_frame(32'h8001_0000, 16, 8'h00, 1'b0, 3*H);
    spi_frame(32'h8002_0000, 16, 8'h00, 1'b0, 4*H);
    check("t5_we_count", 32'(we_seen - we0), 32'd2);
    check("t5_wdata", 32'(bus.reg_wdata), 32'h02);

    // 6: deselect in the same cycle as the final data bit
    we0 = we_seen;
    spi_frame(32'h8077_0000, 16, 8'h00, 1'b1, 4*H);
    check("t6_we_count", 32'(we_seen - we0), 32'd1);
    check("t6_wdata", 32'(bus.reg_wdata), 32'h77);

    // 7: reset in the middle of the data phase, then a clean write
    we0 = we_seen;
    wait_clk(H);
    bus.spi_cs_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 12; i++) begin
      bus.spi_mosi = (i == 0) || (i >= 8);
      wait_clk(H);
      bus.spi_sclk = 1'b1;
      wait_clk(H);
      bus.spi_sclk = 1'b0;
    end
    rst_n = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    wq.delete();
    last_w = 8'h00;
    wait_clk(4);
    check("t7_rst_wdata", 32'(bus.reg_wdata), 32'd0);
    check("t7_rst_miso",  32'(bus.spi_miso),  32'd0);
    rst_n = 1'b1;
    wait_clk(4);
    spi_frame(32'h80A5_0000, 16, 8'h5A, 1'b0, 4*H);
    check("t7_we_count", 32'(we_seen - we0), 32'd1);
    check("t7_wdata", 32'(bus.reg_wdata), 32'hA5);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      int   sel, nb;
      bit   cwl;
      sel = $urandom_range(0, 9);
      cwl = 1'b0;
      if (sel < 6)       nb = 16;
      else if (sel == 6) nb = $urandom_range(0, 15);
      else if (sel == 7) nb = $urandom_range(17, 24);
      else begin         nb = 16; cwl = 1'b1; end
      spi_frame($urandom, nb, 8'($urandom), cwl, 3*H + $urandom_range(0, 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
